muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] ALUOP_RTYPE = 3'b010;

    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply step or
// restoring divide step on the {hi, lo} accumulator pair.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Multiply: add multiplicand when the multiplier LSB is set, then shift
    // the pair right. Divide: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits.
    always_comb begin
        // NOTE: every output gets a value on every path so no latch is inferred.
        hi_out  = hi_in;
        lo_out  = lo_in;
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
        shifted = {hi_in, lo_in[WIDTH-1]};
        // The true difference is below 2**WIDTH whenever it is used, so the
        // truncated subtraction is exact.
        diff    = shifted[WIDTH-1:0] - operand;
        if (div) begin
            if (shifted >= {1'b0, operand}) begin
                hi_out = diff;
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end else begin
                hi_out = shifted[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_out = sum[WIDTH:1];
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// Magnitudes are iterated for WIDTH cycles, then signs are applied in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi, acc_lo, operand;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic               op_div, neg_p, neg_r, dbz_pend;

    logic               is_rtype, idle, cmd_mul, cmd_div, cmd_signed;
    logic               go_md, go_mthi, go_mtlo;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [2*WIDTH-1:0] prod;

    assign is_rtype   = (ALUOp == ALUOP_RTYPE);
    assign idle       = (state_q == IDLE);
    assign cmd_mul    = is_rtype && (func == FUNC_MULT || func == FUNC_MULTU);
    assign cmd_div    = DIV_EN && is_rtype && (func == FUNC_DIV || func == FUNC_DIVU);
    assign cmd_signed = (func == FUNC_MULT || func == FUNC_DIV);
    assign go_md      = start && idle && (cmd_mul || cmd_div);
    assign go_mthi    = start && idle && is_rtype && (func == FUNC_MTHI);
    assign go_mtlo    = start && idle && is_rtype && (func == FUNC_MTLO);
    assign a_mag      = (cmd_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag      = (cmd_signed && b[WIDTH-1]) ? -b : b;
    assign busy       = !idle;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div     (op_div),
        .hi_in   (acc_hi),
        .lo_in   (acc_lo),
        .operand (operand),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: IDLE -> RUN on a mult/div, RUN for WIDTH cycles, one FIX cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_md) state_d = RUN;
            RUN:     if (cnt == CNT_LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Signed results from the unsigned magnitudes left in the accumulator.
    always_comb begin
        prod = {acc_hi, acc_lo};
        if (neg_p) prod = -prod;
        quo = neg_p ? -acc_lo : acc_lo;
        rem = neg_r ? -acc_hi : acc_hi;
    end

    // Operand capture, iteration, result write-back and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset as well so an aborted operation
        // leaves nothing behind.
        if (!rst_n) begin
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            operand     <= '0;
            op_div      <= 1'b0;
            neg_p       <= 1'b0;
            neg_r       <= 1'b0;
            dbz_pend    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update
            // based on the pre-edge values.
            done <= (state_q == FIX);
            case (state_q)
                IDLE: begin
                    if (go_md) begin
                        cnt         <= '0;
                        acc_hi      <= '0;
                        acc_lo      <= cmd_div ? a_mag : b_mag;
                        operand     <= cmd_div ? b_mag : a_mag;
                        op_div      <= cmd_div;
                        neg_p       <= cmd_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r       <= cmd_div && cmd_signed && a[WIDTH-1];
                        dbz_pend    <= cmd_div && (b == '0);
                        div_by_zero <= 1'b0;
                    end else if (go_mthi) begin
                        hi          <= a;
                        div_by_zero <= 1'b0;
                    end else if (go_mtlo) begin
                        lo          <= a;
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (op_div) begin
                        // Divide by zero leaves |a| as remainder; its sign fix restores a.
                        lo          <= dbz_pend ? '1 : quo;
                        hi          <= rem;
                        div_by_zero <= dbz_pend;
                    end else begin
                        {hi, lo} <= prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32: directed vector table,
// hand-written timing sequences and randomized commands vs a reference model.
module tb_muldiv_unit;

    localparam int         W     = 32;
    localparam int         LAT   = W + 2;
    localparam logic [2:0] R_ALU = 3'b010;
    localparam logic [5:0] T_MULT  = 6'b011000;
    localparam logic [5:0] T_MULTU = 6'b011001;
    localparam logic [5:0] T_DIV   = 6'b011010;
    localparam logic [5:0] T_DIVU  = 6'b011011;
    localparam logic [5:0] T_MTHI  = 6'b010001;
    localparam logic [5:0] T_MTLO  = 6'b010011;
    localparam logic [5:0] T_ADD   = 6'b100000;

    logic         clk, rst_n, start;
    logic [2:0]   alu;
    logic [5:0]   func;
    logic [W-1:0] a, b;
    logic         busy, done, dbz;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_hi, m_lo;
    logic         m_dbz;

    typedef struct {
        logic [2:0]   alu;
        logic [5:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vecs[15];

    muldiv_unit #(.WIDTH(W), .DIV_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ALUOp       (alu),
        .func        (func),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit is_md(input logic [2:0] op_alu, input logic [5:0] f);
        return op_alu == R_ALU && (f == T_MULT || f == T_MULTU || f == T_DIV || f == T_DIVU);
    endfunction

    // Reference model: architectural effect of one command on HI/LO/flag.
    task automatic model_step(input logic [2:0] op_alu, input logic [5:0] f,
                              input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        logic [63:0] p;
        int sa, sb;
        sa = op_a;
        sb = op_b;
        if (op_alu == R_ALU) begin
            case (f)
                T_MULT: begin
                    p = 64'(longint'(sa) * longint'(sb));
                    {m_hi, m_lo} = p;
                    m_dbz = 1'b0;
                end
                T_MULTU: begin
                    p = 64'(op_a) * 64'(op_b);
                    {m_hi, m_lo} = p;
                    m_dbz = 1'b0;
                end
                T_DIV: begin
                    m_dbz = (op_b == 0);
                    if (op_b == 0) begin
                        m_lo = '1;
                        m_hi = op_a;
                    end else if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
                        m_lo = op_a;
                        m_hi = '0;
                    end else begin
                        m_lo = 32'(sa / sb);
                        m_hi = 32'(sa % sb);
                    end
                end
                T_DIVU: begin
                    m_dbz = (op_b == 0);
                    if (op_b == 0) begin
                        m_lo = '1;
                        m_hi = op_a;
                    end else begin
                        m_lo = op_a / op_b;
                        m_hi = op_a % op_b;
                    end
                end
                T_MTHI: begin m_hi = op_a; m_dbz = 1'b0; end
                T_MTLO: begin m_lo = op_a; m_dbz = 1'b0; end
                default: ;
            endcase
        end
    endtask

    // Called at a negedge; issues the command at once and returns at the
    // negedge where its effect is visible (the done cycle for mult/div).
    task automatic run_cmd(input logic [2:0] op_alu, input logic [5:0] f,
                           input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                           input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                           input logic e_dbz, input string tag);
        int lat, busy_cycles;
        alu   = op_alu;
        func  = f;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        if (is_md(op_alu, f)) begin
            lat = 0;
            busy_cycles = 0;
            for (int n = 1; n <= LAT + 20; n++) begin
                @(negedge clk);
                if (n == 1) begin
                    start = 1'b0;
                    a = ~op_a;
                    b = ~op_b;
                end
                if (done) begin
                    lat = n;
                    break;
                end
                if (busy) busy_cycles++;
            end
            check($sformatf("%s latency", tag), lat, LAT);
            check($sformatf("%s busy_cycles", tag), busy_cycles, LAT - 1);
        end else begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("%s busy", tag), busy, 0);
            check($sformatf("%s done", tag), done, 0);
        end
        check($sformatf("%s hi", tag), hi, e_hi);
        check($sformatf("%s lo", tag), lo, e_lo);
        check($sformatf("%s dbz", tag), dbz, e_dbz);
    endtask

    initial begin
        int dcount, bcount, first;
        logic [W-1:0] cap_hi, cap_lo;
        logic [2:0]   r_alu;
        logic [5:0]   r_f;
        logic [W-1:0] r_a, r_b;
        logic [5:0]   fset[7];

        vecs[0]  = '{R_ALU,  T_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{R_ALU,  T_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{R_ALU,  T_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{R_ALU,  T_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0};
        vecs[4]  = '{R_ALU,  T_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        vecs[5]  = '{R_ALU,  T_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{3'b000, T_MULT,  32'd9,         32'd9,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{R_ALU,  T_ADD,   32'd9,         32'd9,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{R_ALU,  T_MTLO,  32'h0000_0ABC, 32'd0,         32'd5,         32'h0000_0ABC, 1'b0};
        vecs[9]  = '{R_ALU,  T_MTHI,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'h0000_0ABC, 1'b0};
        vecs[10] = '{R_ALU,  T_DIV,   32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        vecs[11] = '{R_ALU,  T_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
        vecs[12] = '{R_ALU,  T_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0};
        vecs[13] = '{R_ALU,  T_MULTU, 32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0,         1'b0};
        vecs[14] = '{R_ALU,  T_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        alu   = '0;
        func  = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dbz", dbz, 0);
        rst_n = 1'b1;

        // Directed table; commands are issued back to back, so each mult/div
        // after another starts in the previous done cycle.
        foreach (vecs[i])
            run_cmd(vecs[i].alu, vecs[i].f, vecs[i].a, vecs[i].b,
                    vecs[i].hi, vecs[i].lo, vecs[i].dbz, $sformatf("vec%0d", i));

        // A second start while busy must be ignored.
        @(negedge clk);
        alu = R_ALU; func = T_MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
        dcount = 0; first = 0; cap_hi = '1; cap_lo = '1;
        for (int n = 1; n <= LAT + 16; n++) begin
            @(negedge clk);
            start = (n == 5);
            if (n == 5) begin a = 32'd100; b = 32'd200; end
            if (done) begin
                dcount++;
                if (first == 0) begin first = n; cap_hi = hi; cap_lo = lo; end
            end
        end
        check("busy_ignore done_count", dcount, 1);
        check("busy_ignore latency", first, LAT);
        check("busy_ignore hi", cap_hi, 0);
        check("busy_ignore lo", cap_lo, 15);

        // Asynchronous reset in the middle of RUN.
        run_cmd(R_ALU, T_MTHI, 32'h0000_BEEF, 32'd0, 32'h0000_BEEF, 32'd15, 1'b0, "pre_reset mthi");
        alu = R_ALU; func = T_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midrun busy before reset", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun reset busy", busy, 0);
        check("midrun reset hi", hi, 0);
        check("midrun reset lo", lo, 0);
        check("midrun reset done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0; bcount = 0;
        repeat (LAT + 8) begin
            @(negedge clk);
            if (done) dcount++;
            if (busy) bcount++;
        end
        check("after reset done_count", dcount, 0);
        check("after reset busy_count", bcount, 0);

        // First rising edge after reset release accepts a start.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        alu = R_ALU; func = T_MTLO; a = 32'h77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first edge after reset lo", lo, 32'h77);
        check("first edge after reset hi", hi, 0);

        // Randomized commands against the reference model.
        m_hi = '0; m_lo = 32'h77; m_dbz = 1'b0;
        fset[0] = T_MULT; fset[1] = T_MULTU; fset[2] = T_DIV; fset[3] = T_DIVU;
        fset[4] = T_MTHI; fset[5] = T_MTLO;  fset[6] = T_ADD;
        for (int i = 0; i < 40; i++) begin
            r_alu = ($urandom_range(0, 9) == 0) ? 3'b000 : R_ALU;
            r_f   = fset[$urandom_range(0, 6)];
            r_a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       r_b = 32'd0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = $urandom_range(1, 9);
                default: r_b = $urandom;
            endcase
            model_step(r_alu, r_f, r_a, r_b);
            run_cmd(r_alu, r_f, r_a, r_b, m_hi, m_lo, m_dbz, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
